// File: rtl/am_counter_bank.sv
// Handler/counter bank: per-kernel saturating arrival counters fed by single-beat AM
// notifications, with host-programmable thresholds, level interrupts and an AXI4-Lite control port.
module am_counter_bank #(
    parameter int NUM_KERNELS    = 16,
    parameter int ADDRESS_OFFSET = 0,
    parameter int COUNTER_WIDTH  = 16,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic [63:0]             axis_handler_tdata,
    input  logic                    axis_handler_tvalid,
    output logic                    axis_handler_tready,
    input  logic                    axis_handler_tlast,

    input  logic [ADDR_WIDTH-1:0]   s_axi_ctrl_bus_awaddr,
    input  logic                    s_axi_ctrl_bus_awvalid,
    output logic                    s_axi_ctrl_bus_awready,
    input  logic [31:0]             s_axi_ctrl_bus_wdata,
    input  logic [3:0]              s_axi_ctrl_bus_wstrb,
    input  logic                    s_axi_ctrl_bus_wvalid,
    output logic                    s_axi_ctrl_bus_wready,
    output logic [1:0]              s_axi_ctrl_bus_bresp,
    output logic                    s_axi_ctrl_bus_bvalid,
    input  logic                    s_axi_ctrl_bus_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ctrl_bus_araddr,
    input  logic                    s_axi_ctrl_bus_arvalid,
    output logic                    s_axi_ctrl_bus_arready,
    output logic [31:0]             s_axi_ctrl_bus_rdata,
    output logic [1:0]              s_axi_ctrl_bus_rresp,
    output logic                    s_axi_ctrl_bus_rvalid,
    input  logic                    s_axi_ctrl_bus_rready,

    output logic [NUM_KERNELS-1:0]  interrupt
);

    localparam int CW    = COUNTER_WIDTH;
    localparam int SUM_W = 34;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CW){1'b0}}, {CW{1'b1}}};

    // Handshake semantics: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its payload until then, ready may be given at will.

    // ---------------- state ----------------
    logic [CW-1:0]          count_q   [NUM_KERNELS];
    logic [CW-1:0]          count_nxt [NUM_KERNELS];
    logic [CW-1:0]          thresh_q  [NUM_KERNELS];
    logic [CW-1:0]          thresh_nxt[NUM_KERNELS];
    logic [NUM_KERNELS-1:0] enable_q;
    logic [NUM_KERNELS-1:0] enable_nxt;
    logic [NUM_KERNELS-1:0] irq_cond;
    logic [31:0]            drop_q;
    logic [31:0]            drop_nxt;

    // ---------------- handler stream ----------------
    logic        tready_q;
    logic        first_q;
    logic        beat;
    logic        upd;
    logic        in_range;
    logic [15:0] hid;
    logic [15:0] hinc;
    logic [32:0] hidx;

    assign hid      = axis_handler_tdata[15:0];
    assign hinc     = axis_handler_tdata[31:16];
    assign hidx     = 33'(hid) - 33'(ADDRESS_OFFSET);
    assign in_range = (33'(hid) >= 33'(ADDRESS_OFFSET)) && (hidx < 33'(NUM_KERNELS));
    assign beat     = axis_handler_tvalid && tready_q;
    assign upd      = beat && first_q;

    assign axis_handler_tready = tready_q;

    // Only the first beat of a packet carries a notification; the rest are swallowed.
    always_ff @(posedge clock) begin
        if (reset) begin
            tready_q <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            tready_q <= 1'b1;
            if (beat) begin
                first_q <= axis_handler_tlast;
            end
        end
    end

    // ---------------- write decode ----------------
    logic        aw_w_ready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        wr_en;
    logic [31:0] wmask;
    logic [31:0] wdata_m;
    logic [31:0] wr_kidx;
    logic [1:0]  wr_reg;
    logic        wr_in_kern;
    logic        wr_is_drop;

    assign wr_en      = aw_w_ready_q && s_axi_ctrl_bus_awvalid && s_axi_ctrl_bus_wvalid;
    assign wmask      = {{8{s_axi_ctrl_bus_wstrb[3]}}, {8{s_axi_ctrl_bus_wstrb[2]}},
                         {8{s_axi_ctrl_bus_wstrb[1]}}, {8{s_axi_ctrl_bus_wstrb[0]}}};
    assign wdata_m    = s_axi_ctrl_bus_wdata & wmask;
    assign wr_kidx    = 32'(s_axi_ctrl_bus_awaddr[ADDR_WIDTH-1:4]);
    assign wr_reg     = s_axi_ctrl_bus_awaddr[3:2];
    assign wr_in_kern = wr_kidx < 32'(NUM_KERNELS);
    assign wr_is_drop = 32'(s_axi_ctrl_bus_awaddr[ADDR_WIDTH-1:2]) == 32'(NUM_KERNELS * 4);

    // ---------------- per-kernel next state ----------------
    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_kernel
        logic             hit;
        logic             sel;
        logic             cnt_wr;
        logic             thr_wr;
        logic             ctl_wr;
        logic             clr;
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] sub;
        logic [SUM_W-1:0] diff;

        assign hit    = upd && in_range && (hidx == 33'(k));
        assign sel    = wr_en && wr_in_kern && (wr_kidx == 32'(k));
        assign cnt_wr = sel && (wr_reg == 2'd0);
        assign thr_wr = sel && (wr_reg == 2'd1);
        assign ctl_wr = sel && (wr_reg == 2'd2);
        assign clr    = ctl_wr && wdata_m[1];

        // Increment, CLEAR and COUNT-subtract fold into one wide sum clamped to [0, max].
        assign sum  = (clr ? '0 : SUM_W'(count_q[k])) + (hit ? SUM_W'(hinc) : '0);
        assign sub  = cnt_wr ? SUM_W'(wdata_m) : '0;
        assign diff = sum - sub;

        assign count_nxt[k]  = (sub >= sum) ? '0 :
                               (diff > CNT_MAX) ? {CW{1'b1}} : diff[CW-1:0];
        assign thresh_nxt[k] = thr_wr ? wdata_m[CW-1:0] : thresh_q[k];
        assign enable_nxt[k] = ctl_wr ? wdata_m[0] : enable_q[k];
        assign irq_cond[k]   = enable_q[k] && (thresh_q[k] != '0) && (count_q[k] >= thresh_q[k]);
    end

    always_comb begin
        drop_nxt = (wr_en && wr_is_drop) ? '0 : drop_q;
        if (upd && !in_range && (drop_nxt != 32'hFFFF_FFFF)) begin
            drop_nxt = drop_nxt + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                count_q[k]  <= '0;
                thresh_q[k] <= '0;
            end
            enable_q  <= '0;
            drop_q    <= '0;
            interrupt <= '0;
        end else begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                count_q[k]  <= count_nxt[k];
                thresh_q[k] <= thresh_nxt[k];
            end
            enable_q  <= enable_nxt;
            drop_q    <= drop_nxt;
            interrupt <= irq_cond;
        end
    end

    // ---------------- read decode ----------------
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rd_en;
    logic [31:0] rd_kidx;
    logic [1:0]  rd_reg;
    logic        rd_is_drop;
    logic [31:0] rd_data;
    logic        rd_err;

    assign rd_en      = arready_q && s_axi_ctrl_bus_arvalid;
    assign rd_kidx    = 32'(s_axi_ctrl_bus_araddr[ADDR_WIDTH-1:4]);
    assign rd_reg     = s_axi_ctrl_bus_araddr[3:2];
    assign rd_is_drop = 32'(s_axi_ctrl_bus_araddr[ADDR_WIDTH-1:2]) == 32'(NUM_KERNELS * 4);

    // Reads sample next-state so they see every update landing in the ARREADY cycle.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_is_drop) begin
            rd_data = drop_nxt;
        end else if (rd_kidx < 32'(NUM_KERNELS)) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (rd_kidx == 32'(k)) begin
                    case (rd_reg)
                        2'd0:    rd_data = 32'(count_nxt[k]);
                        2'd1:    rd_data = 32'(thresh_nxt[k]);
                        2'd2:    rd_data = {31'b0, enable_nxt[k]};
                        default: rd_data = '0;
                    endcase
                end
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    // ---------------- AXI4-Lite channel registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_w_ready_q <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= 2'b00;
        end else begin
            aw_w_ready_q <= !aw_w_ready_q && s_axi_ctrl_bus_awvalid &&
                            s_axi_ctrl_bus_wvalid && !bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (wr_in_kern || wr_is_drop) ? 2'b00 : 2'b10;
            end else if (bvalid_q && s_axi_ctrl_bus_bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= !arready_q && s_axi_ctrl_bus_arvalid && !rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_err ? 2'b10 : 2'b00;
            end else if (rvalid_q && s_axi_ctrl_bus_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_ctrl_bus_awready = aw_w_ready_q;
    assign s_axi_ctrl_bus_wready  = aw_w_ready_q;
    assign s_axi_ctrl_bus_bvalid  = bvalid_q;
    assign s_axi_ctrl_bus_bresp   = bresp_q;
    assign s_axi_ctrl_bus_arready = arready_q;
    assign s_axi_ctrl_bus_rvalid  = rvalid_q;
    assign s_axi_ctrl_bus_rdata   = rdata_q;
    assign s_axi_ctrl_bus_rresp   = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{axis_handler_tdata[63:32], s_axi_ctrl_bus_awaddr[1:0],
                           s_axi_ctrl_bus_araddr[1:0]};

endmodule

// File: tb/tb_am_counter_bank.sv
// Bench for am_counter_bank: directed scenarios plus random traffic, checked against an
// arithmetic model of the counter bank through read/write response queues.
module tb_am_counter_bank;

    localparam int    NK   = 4;
    localparam int    OFF  = 8;
    localparam int    CW   = 8;
    localparam int    AW   = 10;
    localparam longint MAXC = 255;

    logic          clock = 1'b0;
    logic          reset;
    logic [63:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [NK-1:0] interrupt;

    am_counter_bank #(
        .NUM_KERNELS(NK), .ADDRESS_OFFSET(OFF), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .axis_handler_tdata(tdata), .axis_handler_tvalid(tvalid),
        .axis_handler_tready(tready), .axis_handler_tlast(tlast),
        .s_axi_ctrl_bus_awaddr(awaddr), .s_axi_ctrl_bus_awvalid(awvalid),
        .s_axi_ctrl_bus_awready(awready),
        .s_axi_ctrl_bus_wdata(wdata), .s_axi_ctrl_bus_wstrb(wstrb),
        .s_axi_ctrl_bus_wvalid(wvalid), .s_axi_ctrl_bus_wready(wready),
        .s_axi_ctrl_bus_bresp(bresp), .s_axi_ctrl_bus_bvalid(bvalid),
        .s_axi_ctrl_bus_bready(bready),
        .s_axi_ctrl_bus_araddr(araddr), .s_axi_ctrl_bus_arvalid(arvalid),
        .s_axi_ctrl_bus_arready(arready),
        .s_axi_ctrl_bus_rdata(rdata), .s_axi_ctrl_bus_rresp(rresp),
        .s_axi_ctrl_bus_rvalid(rvalid), .s_axi_ctrl_bus_rready(rready),
        .interrupt(interrupt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_rq[$];
    logic [1:0]  exp_bq[$];

    longint mcount[NK];
    longint mthresh[NK];
    bit     men[NK];
    longint mdrop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            mcount[k] = 0; mthresh[k] = 0; men[k] = 0;
        end
        mdrop = 0;
    endtask

    function automatic logic [1:0] model_apply(input bit has_beat, input int id, input int inc,
                                               input bit has_wr, input int addr,
                                               input logic [31:0] data);
        int     hk = -1;
        int     wk = addr >> 4;
        int     wr = (addr >> 2) & 3;
        bit     wdrop = ((addr >> 2) == NK * 4);
        longint v;
        logic [1:0] resp = 2'b00;
        if (has_wr && wdrop) mdrop = 0;
        if (has_wr && !(wk < NK) && !wdrop) resp = 2'b10;
        if (has_beat) begin
            if (id < OFF || id - OFF >= NK) begin
                if (mdrop < 64'hFFFF_FFFF) mdrop++;
            end else begin
                hk = id - OFF;
            end
        end
        for (int k = 0; k < NK; k++) begin
            v = mcount[k];
            if (has_wr && wk == k && wr == 2 && data[1]) v = 0;
            if (hk == k) v = v + inc;
            if (has_wr && wk == k && wr == 0) v = v - longint'({32'b0, data});
            if (v < 0) v = 0;
            if (v > MAXC) v = MAXC;
            mcount[k] = v;
            if (has_wr && wk == k && wr == 1) mthresh[k] = longint'({32'b0, data}) & MAXC;
            if (has_wr && wk == k && wr == 2) men[k] = data[0];
        end
        return resp;
    endfunction

    function automatic logic [33:0] model_read(input int addr);
        int wk = addr >> 4;
        int wr = (addr >> 2) & 3;
        if ((addr >> 2) == NK * 4) return {2'b00, 32'(mdrop)};
        if (wk >= NK) return {2'b10, 32'h0};
        case (wr)
            0:       return {2'b00, 32'(mcount[wk])};
            1:       return {2'b00, 32'(mthresh[wk])};
            2:       return {2'b00, 31'b0, men[wk]};
            default: return {2'b00, 32'h0};
        endcase
    endfunction

    function automatic logic [NK-1:0] model_irq();
        logic [NK-1:0] v = '0;
        for (int k = 0; k < NK; k++)
            v[k] = men[k] && (mthresh[k] != 0) && (mcount[k] >= mthresh[k]);
        return v;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset && bvalid && bready) begin
                if (exp_bq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_b: got bresp %0d, required no response", bresp);
                end else begin
                    check("bresp", 64'(bresp), 64'(exp_bq.pop_front()));
                end
            end
            if (!reset && rvalid && rready) begin
                if (exp_rq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_r: got rdata 0x%0h, required no response", rdata);
                end else begin
                    e = exp_rq.pop_front();
                    check("rresp_rdata", 64'({rresp, rdata}), 64'(e));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_b_empty();
        int c = 0;
        while (exp_bq.size() != 0 && c < 40) begin @(negedge clock); c++; end
        if (exp_bq.size() != 0) begin timeout_fail("b_wait"); exp_bq.delete(); end
    endtask

    task automatic wait_r_empty();
        int c = 0;
        while (exp_rq.size() != 0 && c < 40) begin @(negedge clock); c++; end
        if (exp_rq.size() != 0) begin timeout_fail("r_wait"); exp_rq.delete(); end
    endtask

    task automatic send_packet(input int id, input int inc, input int nb);
        int c;
        for (int b = 0; b < nb; b++) begin
            @(negedge clock);
            tvalid = 1'b1;
            tlast  = (b == nb - 1);
            tdata  = (b == 0) ? {32'($urandom), 16'(inc), 16'(id)}
                              : {32'($urandom), 16'($urandom), 16'($urandom)};
            c = 0;
            while (!tready && c < 20) begin @(negedge clock); c++; end
            if (!tready) begin timeout_fail("tready_wait"); tvalid = 1'b0; return; end
            if (b == 0) void'(model_apply(1'b1, id, inc, 1'b0, 0, 32'h0));
        end
        @(negedge clock);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic axi_write(input int addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_lead, input bit co_beat, input int bid,
                             input int binc, input bit wait_b);
        logic [31:0] m;
        int c;
        @(negedge clock);
        awaddr  = AW'(addr);
        awvalid = 1'b1;
        repeat (aw_lead) @(negedge clock);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        @(negedge clock);
        c = 0;
        while (!awready && c < 20) begin @(negedge clock); c++; end
        if (!awready) begin
            timeout_fail("awready_wait");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (co_beat) begin
            tvalid = 1'b1;
            tlast  = 1'b1;
            tdata  = {32'($urandom), 16'(binc), 16'(bid)};
        end
        m = data & {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        exp_bq.push_back(model_apply(co_beat, bid, binc, 1'b1, addr, m));
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        if (wait_b) wait_b_empty();
    endtask

    task automatic axi_read(input int addr, input int hold);
        logic [33:0] e;
        int c;
        @(negedge clock);
        araddr  = AW'(addr);
        arvalid = 1'b1;
        rready  = (hold == 0);
        @(negedge clock);
        c = 0;
        while (!arready && c < 20) begin @(negedge clock); c++; end
        if (!arready) begin
            timeout_fail("arready_wait");
            arvalid = 1'b0; rready = 1'b1;
            return;
        end
        e = model_read(addr);
        exp_rq.push_back(e);
        @(negedge clock);
        arvalid = 1'b0;
        if (hold > 0) begin
            c = 0;
            while (!rvalid && c < 20) begin @(negedge clock); c++; end
            repeat (hold) begin
                check("r_hold_valid", 64'(rvalid), 64'd1);
                check("r_hold_data", 64'({rresp, rdata}), 64'(e));
                @(negedge clock);
            end
            rready = 1'b1;
        end
        wait_r_empty();
    endtask

    task automatic check_irq();
        repeat (3) @(negedge clock);
        check("irq", 64'(interrupt), 64'(model_irq()));
    endtask

    function automatic logic [3:0] rand_strb();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'hF;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int op, k, r, a;
        reset = 1'b1;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        model_reset();

        repeat (3) @(negedge clock);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_irq", 64'(interrupt), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rdata", 64'({rresp, rdata, bresp}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("tready_up", 64'(tready), 64'd1);

        // increment basic
        axi_write(16'h24, 32'd3, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        axi_write(16'h28, 32'd1, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        send_packet(10, 1, 1);
        send_packet(10, 1, 2);
        send_packet(10, 1, 1);
        check("irq2_before", 64'(interrupt[2]), 64'd0);
        @(negedge clock);
        check("irq2_rise", 64'(interrupt), 64'b0100);
        axi_read(16'h20, 0);
        check_irq();

        // saturation
        send_packet(8, 200, 1);
        send_packet(8, 200, 1);
        axi_read(16'h00, 0);
        axi_write(16'h00, 32'd300, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        axi_read(16'h00, 0);

        // range check and DROP
        send_packet(7, 5, 1);
        send_packet(12, 5, 3);
        send_packet(9, 1, 1);
        axi_read(16'h40, 0);
        axi_read(16'h10, 0);
        axi_write(16'h40, 32'h1234, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        axi_read(16'h40, 0);

        // same-cycle events on kernel 1
        send_packet(9, 4, 1);
        axi_read(16'h10, 0);
        axi_write(16'h10, 32'd2, 4'hF, 0, 1'b1, 9, 4, 1'b1);
        axi_read(16'h10, 0);
        axi_write(16'h18, 32'd2, 4'hF, 0, 1'b1, 9, 3, 1'b1);
        axi_read(16'h10, 0);

        // protocol, strobes and decode errors
        axi_write(16'h04, 32'h55, 4'hF, 3, 1'b0, 0, 0, 1'b1);
        axi_read(16'h04, 5);
        axi_read(16'h3F0, 0);
        axi_write(16'h3F0, 32'hFF, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        axi_write(16'h14, 32'h1234_56AB, 4'b0001, 0, 1'b0, 0, 0, 1'b1);
        axi_read(16'h14, 0);
        axi_write(16'h14, 32'h1234_56AB, 4'b1110, 0, 1'b0, 0, 0, 1'b1);
        axi_read(16'h14, 0);
        axi_read(16'h0C, 0);
        check_irq();

        // random traffic
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            k  = $urandom_range(0, NK - 1);
            r  = $urandom_range(0, 2);
            case (op)
                0: send_packet($urandom_range(6, 13), $urandom_range(0, 120), $urandom_range(1, 3));
                1: axi_write(k * 16 + r * 4,
                             (r == 0) ? 32'($urandom_range(0, 80)) :
                             (r == 1) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 3)),
                             rand_strb(), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                             $urandom_range(8, 11), $urandom_range(0, 100), 1'b1);
                2: begin
                    a = $urandom_range(0, 19);
                    if (a < 16) axi_read(a * 4, $urandom_range(0, 1) * 2);
                    else if (a < 18) axi_read(16'h40, 0);
                    else axi_read((a == 18) ? 16'h44 : 16'h3F0, 0);
                end
                3: axi_write(($urandom_range(0, 1) != 0) ? 16'h40 : 16'h44, $urandom,
                             4'hF, 0, 1'b0, 0, 0, 1'b1);
                default: axi_read(k * 16, 0);
            endcase
            check_irq();
        end

        // reset while a write response is pending
        axi_write(16'h38, 32'd3, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        axi_write(16'h34, 32'd9, 4'hF, 0, 1'b0, 0, 0, 1'b1);
        send_packet(11, 9, 1);
        axi_read(16'h30, 0);
        check_irq();
        bready = 1'b0;
        axi_write(16'h34, 32'd9, 4'hF, 0, 1'b0, 0, 0, 1'b0);
        check("pending_bvalid", 64'(bvalid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check("mid_rst_irq", 64'(interrupt), 64'd0);
        check("mid_rst_tready", 64'(tready), 64'd0);
        exp_bq.delete();
        exp_rq.delete();
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        bready = 1'b1;
        repeat (8) @(negedge clock);
        axi_read(16'h30, 0);
        axi_read(16'h34, 0);
        check_irq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
